// File: rtl/data_mem_io.sv
// Data-side memory and I/O block for the single-cycle core: word-addressed RAM plus
// memory-mapped LED, switch, cycle-counter and down-timer registers. Loads are combinational.
module data_mem_io #(
  parameter int unsigned RAM_DEPTH   = 256,
  parameter logic [31:0] IO_BASE     = 32'h0000_1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        mem_write_i,
  input  logic        mem_reg_i,
  output logic [31:0] rd_data_o,
  input  logic [7:0]  sw_in_i,
  output logic [7:0]  led_out_o,
  output logic        timer_irq_o,
  output logic        bad_addr_o
);

  localparam int unsigned RamAw    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [29:0] RamWords = 30'(RAM_DEPTH);
  localparam logic [29:0] IoWord   = IO_BASE[31:2];

  // Byte offset within a word never affects decode or data.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

  logic [29:0]      word;
  logic [RamAw-1:0] ram_idx;
  logic             ram_hit, led_hit, sw_hit, cyc_hit, tcnt_hit, tctl_hit, mapped;

  assign word     = addr_i[31:2];
  assign ram_idx  = addr_i[RamAw+1:2];
  assign ram_hit  = (word < RamWords);
  assign led_hit  = (word == IoWord);
  assign sw_hit   = (word == IoWord + 30'd1);
  assign cyc_hit  = (word == IoWord + 30'd2);
  assign tcnt_hit = (word == IoWord + 30'd3);
  assign tctl_hit = (word == IoWord + 30'd4);
  assign mapped   = ram_hit | led_hit | sw_hit | cyc_hit | tcnt_hit | tctl_hit;

  logic [31:0] ram_q [RAM_DEPTH];
  logic [7:0]  sync_q [SYNC_STAGES];
  logic [7:0]  led_q, led_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] reload_q, reload_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        expired_q, expired_d;
  logic        bad_q, bad_d;
  logic        fire;

  // RAM array: no reset, written on the clock edge of a mapped store.
  always_ff @(posedge clk_i) begin
    if (mem_write_i && ram_hit) begin
      ram_q[ram_idx] <= wr_data_i;
    end
  end

  // Switch synchronizer chain; the last stage is what software sees.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= sw_in_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Next-state for LED, cycle counter, error flag and timer. The timer's IDLE/RUN state is
  // en_q itself; an expiry is any enabled cycle with count <= 1. CPU writes override the
  // timer's own count/en/auto updates, while an expiry beats a write-1-to-clear.
  always_comb begin
    led_d     = led_q;
    cyc_d     = cyc_q + 32'd1;
    bad_d     = bad_q | ((mem_write_i | mem_reg_i) & ~mapped);
    count_d   = count_q;
    reload_d  = reload_q;
    en_d      = en_q;
    auto_d    = auto_q;
    expired_d = expired_q;
    fire      = en_q && (count_q <= 32'd1);

    if (mem_write_i && led_hit) led_d = wr_data_i[7:0];
    if (mem_write_i && cyc_hit) cyc_d = '0;

    if (en_q) begin
      if (!fire) begin
        count_d = count_q - 32'd1;
      end else if (auto_q && (reload_q != '0)) begin
        count_d = reload_q;
      end else begin
        count_d = '0;
        en_d    = 1'b0;
      end
    end

    if (mem_write_i && tctl_hit && wr_data_i[2]) expired_d = 1'b0;
    if (fire) expired_d = 1'b1;

    if (mem_write_i && tcnt_hit) begin
      count_d  = wr_data_i;
      reload_d = wr_data_i;
    end
    if (mem_write_i && tctl_hit) begin
      en_d   = wr_data_i[0];
      auto_d = wr_data_i[1];
    end
  end

  // Register update for all resettable state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led_q     <= '0;
      cyc_q     <= '0;
      count_q   <= '0;
      reload_q  <= '0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      expired_q <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      cyc_q     <= cyc_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      en_q      <= en_d;
      auto_q    <= auto_d;
      expired_q <= expired_d;
      bad_q     <= bad_d;
    end
  end

  // Zero-latency load mux; unmapped or non-load cycles return zero.
  always_comb begin
    rd_data_o = '0;
    if (mem_reg_i) begin
      if (ram_hit)       rd_data_o = ram_q[ram_idx];
      else if (led_hit)  rd_data_o = {24'b0, led_q};
      else if (sw_hit)   rd_data_o = {24'b0, sync_q[SYNC_STAGES-1]};
      else if (cyc_hit)  rd_data_o = cyc_q;
      else if (tcnt_hit) rd_data_o = count_q;
      else if (tctl_hit) rd_data_o = {29'b0, expired_q, auto_q, en_q};
    end
  end

  assign led_out_o   = led_q;
  assign timer_irq_o = expired_q;
  assign bad_addr_o  = bad_q;

endmodule

// File: tb/tb_data_mem_io.sv
// Self-checking bench for data_mem_io: directed steps plus a randomized phase checked
// against a behavioural model of the memory map.
module tb_data_mem_io;

  localparam int unsigned RamDepth   = 256;
  localparam logic [31:0] IoBase     = 32'h0000_1000;
  localparam int unsigned SyncStages = 2;
  localparam logic [31:0] ALed  = IoBase;
  localparam logic [31:0] ASw   = IoBase + 32'h4;
  localparam logic [31:0] ACyc  = IoBase + 32'h8;
  localparam logic [31:0] ATcnt = IoBase + 32'hC;
  localparam logic [31:0] ATctl = IoBase + 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic        mem_write = 1'b0;
  logic        mem_reg = 1'b0;
  logic [31:0] rd_data;
  logic [7:0]  sw_in = '0;
  logic [7:0]  led_out;
  logic        timer_irq;
  logic        bad_addr;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rd;
  logic [7:0]  sw_next = '0;

  // Reference model state
  logic [31:0] m_ram [int];
  int          m_words [$];
  logic [7:0]  m_swq [$];
  logic [7:0]  m_led;
  logic [31:0] m_cyc, m_cnt, m_rel;
  bit          m_en, m_auto, m_exp, m_bad;

  data_mem_io #(
    .RAM_DEPTH  (RamDepth),
    .IO_BASE    (IoBase),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .addr_i     (addr),
    .wr_data_i  (wr_data),
    .mem_write_i(mem_write),
    .mem_reg_i  (mem_reg),
    .rd_data_o  (rd_data),
    .sw_in_i    (sw_in),
    .led_out_o  (led_out),
    .timer_irq_o(timer_irq),
    .bad_addr_o (bad_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_led = '0; m_cyc = '0; m_cnt = '0; m_rel = '0;
    m_en = 0; m_auto = 0; m_exp = 0; m_bad = 0;
    m_swq.delete();
  endtask

  function automatic bit m_mapped(input logic [31:0] a);
    logic [31:0] aa;
    aa = {a[31:2], 2'b00};
    return ((a >> 2) < RamDepth) || aa == ALed || aa == ASw || aa == ACyc ||
           aa == ATcnt || aa == ATctl;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] aa;
    int w;
    aa = {a[31:2], 2'b00};
    w  = int'(a >> 2);
    if ((a >> 2) < RamDepth) return m_ram.exists(w) ? m_ram[w] : 32'h0;
    if (aa == ALed)  return {24'h0, m_led};
    if (aa == ASw)   return (m_swq.size() == SyncStages) ? {24'h0, m_swq[0]} : 32'h0;
    if (aa == ACyc)  return m_cyc;
    if (aa == ATcnt) return m_cnt;
    if (aa == ATctl) return {29'h0, m_exp, m_auto, m_en};
    return 32'h0;
  endfunction

  // One clock edge of the memory map, evaluated from the pre-edge state.
  task automatic m_edge(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] aa;
    bit fire;
    int w;
    aa   = {a[31:2], 2'b00};
    w    = int'(a >> 2);
    fire = m_en && (m_cnt <= 1);
    if ((we || re) && !m_mapped(a)) m_bad = 1;
    m_swq.push_back(sw_in);
    if (m_swq.size() > SyncStages) void'(m_swq.pop_front());
    if (we && aa == ACyc) m_cyc = 0;
    else m_cyc = m_cyc + 1;
    if (m_en) begin
      if (!fire) m_cnt = m_cnt - 1;
      else if (m_auto && m_rel != 0) m_cnt = m_rel;
      else begin
        m_cnt = 0;
        m_en  = 0;
      end
    end
    if (we && aa == ATctl && d[2]) m_exp = 0;
    if (fire) m_exp = 1;
    if (we && aa == ATcnt) begin
      m_cnt = d;
      m_rel = d;
    end
    if (we && aa == ATctl) begin
      m_en   = d[0];
      m_auto = d[1];
    end
    if (we && (a >> 2) < RamDepth) begin
      if (!m_ram.exists(w)) m_words.push_back(w);
      m_ram[w] = d;
    end
    if (we && aa == ALed) m_led = d[7:0];
  endtask

  // One CPU cycle: drive at negedge, check load data, clock, check registered outputs.
  task automatic step(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    @(negedge clk);
    mem_write = we; mem_reg = re; addr = a; wr_data = d; sw_in = sw_next;
    #1;
    exp_rd  = re ? m_read(a) : 32'h0;
    last_rd = rd_data;
    chk("rd_data", rd_data, exp_rd);
    @(posedge clk);
    m_edge(we, re, a, d);
    #1;
    mem_write = 0; mem_reg = 0;
    chk("led_out", {24'h0, led_out}, {24'h0, m_led});
    chk("timer_irq", {31'h0, timer_irq}, {31'h0, m_exp});
    chk("bad_addr", {31'h0, bad_addr}, {31'h0, m_bad});
  endtask

  int unsigned op;
  int unsigned sub;
  logic [31:0] lo;

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_led", {24'h0, led_out}, 32'h0);
    chk("reset_irq", {31'h0, timer_irq}, 32'h0);
    chk("reset_bad", {31'h0, bad_addr}, 32'h0);

    // Cycle counter from reset, then write-clear
    repeat (10) step(0, 0, 32'h0, 32'h0);
    step(0, 1, ACyc, 32'h0);
    chk("cycles_10", last_rd, 32'd10);
    step(1, 0, ACyc, 32'hFFFF_0000);
    step(0, 1, ACyc, 32'h0);
    chk("cycles_after_clr", last_rd, 32'd0);
    step(0, 1, ACyc, 32'h0);
    chk("cycles_one_later", last_rd, 32'd1);

    // RAM
    step(1, 0, 32'h10, 32'hDEAD_BEEF);
    step(1, 0, 32'h3FC, 32'h1234_5678);
    step(0, 1, 32'h10, 32'h0);
    chk("ram_10", last_rd, 32'hDEAD_BEEF);
    step(0, 1, 32'h3FF, 32'h0);
    chk("ram_3fc", last_rd, 32'h1234_5678);
    step(0, 0, 32'h10, 32'h0);
    chk("ram_noload", last_rd, 32'h0);

    // LED and switches; stores to SW are silently ignored
    step(1, 0, ALed, 32'h1A5);
    chk("led_a5", {24'h0, led_out}, 32'hA5);
    step(0, 1, ALed, 32'h0);
    chk("led_read", last_rd, 32'hA5);
    step(1, 0, ASw, 32'hFF);
    chk("sw_store_ok", {31'h0, bad_addr}, 32'h0);
    sw_next = 8'h3C;
    step(0, 1, ASw, 32'h0);
    chk("sw_edge0", last_rd, 32'h0);
    step(0, 1, ASw, 32'h0);
    chk("sw_edge1", last_rd, 32'h0);
    step(0, 1, ASw, 32'h0);
    chk("sw_edge2", last_rd, 32'h3C);

    // One-shot timer
    step(1, 0, ATcnt, 32'd5);
    step(1, 0, ATctl, 32'd1);
    step(0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, ATcnt, 32'h0);
      chk("oneshot_cnt", last_rd, 32'(4 - i));
    end
    chk("oneshot_irq", {31'h0, timer_irq}, 32'h1);
    step(0, 1, ATctl, 32'h0);
    chk("oneshot_ctl", last_rd, 32'h4);
    step(0, 1, ATcnt, 32'h0);
    chk("oneshot_zero", last_rd, 32'h0);
    step(1, 0, ATctl, 32'h4);
    chk("oneshot_clr", {31'h0, timer_irq}, 32'h0);

    // Auto-reload timer, including clear colliding with expiry
    step(1, 0, ATcnt, 32'd3);
    step(1, 0, ATctl, 32'd3);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, ATcnt, 32'h0);
      chk("auto_cnt", last_rd, 32'(3 - i));
    end
    chk("auto_irq", {31'h0, timer_irq}, 32'h1);
    step(1, 0, ATctl, 32'd7);
    chk("auto_clr", {31'h0, timer_irq}, 32'h0);
    step(0, 1, ATcnt, 32'h0);
    chk("auto_cnt2", last_rd, 32'd2);
    step(1, 0, ATctl, 32'd7);
    chk("auto_set_wins", {31'h0, timer_irq}, 32'h1);
    step(0, 1, ATcnt, 32'h0);
    chk("auto_reload", last_rd, 32'd3);
    step(1, 0, ATctl, 32'd4);

    // Randomized traffic over all mapped registers
    for (int n = 0; n < 400; n++) begin
      op  = $urandom_range(0, 9);
      sub = $urandom_range(0, 3);
      lo  = 32'($urandom_range(0, 3));
      case (op)
        0, 1, 2: step(1, 0, (32'($urandom_range(0, RamDepth - 1)) << 2) | lo, $urandom);
        3, 4: begin
          if (m_words.size() > 0)
            step(0, 1, (32'(m_words[$urandom_range(0, m_words.size() - 1)]) << 2) | lo, 32'h0);
          else step(0, 0, 32'h0, 32'h0);
        end
        5: step(sub[0], !sub[0], ALed | lo, $urandom);
        6: begin
          if (sub == 0) sw_next = 8'($urandom);
          step(0, 1, ASw | lo, 32'h0);
        end
        7: step(0, 0, 32'h0, 32'h0);
        8: begin
          if (sub == 0) step(1, 0, ATcnt | lo, 32'($urandom_range(0, 5)));
          else if (sub == 1) step(1, 0, ATctl | lo, 32'($urandom_range(0, 7)));
          else if (sub == 2) step(0, 1, ATcnt | lo, 32'h0);
          else step(0, 1, ATctl | lo, 32'h0);
        end
        default: step(sub == 0, sub != 0, ACyc | lo, $urandom);
      endcase
    end

    // Unmapped access sets a sticky error flag
    step(0, 1, 32'h2000, 32'h0);
    chk("bad_rd", last_rd, 32'h0);
    chk("bad_set", {31'h0, bad_addr}, 32'h1);
    step(0, 0, 32'h0, 32'h0);
    step(0, 1, ALed, 32'h0);
    chk("bad_sticky", {31'h0, bad_addr}, 32'h1);

    // Asynchronous reset in the middle of an auto-reload countdown
    step(1, 0, ALed, 32'h5A);
    step(1, 0, ATcnt, 32'd2);
    step(1, 0, ATctl, 32'd3);
    repeat (3) step(0, 0, 32'h0, 32'h0);
    chk("pre_rst_irq", {31'h0, timer_irq}, 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_led", {24'h0, led_out}, 32'h0);
    chk("rst_irq", {31'h0, timer_irq}, 32'h0);
    chk("rst_bad", {31'h0, bad_addr}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
    step(0, 1, ATcnt, 32'h0);
    chk("rst_tcount", last_rd, 32'h0);
    step(0, 1, ATctl, 32'h0);
    chk("rst_tctrl", last_rd, 32'h0);
    repeat (2) step(0, 0, 32'h0, 32'h0);
    step(0, 1, ATcnt, 32'h0);
    chk("rst_idle", last_rd, 32'h0);
    step(0, 1, 32'h10, 32'h0);
    chk("ram_survives_rst", last_rd, m_read(32'h10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
- Data-side memory and I/O block directly downstream of the single-cycle CPU core.
- Takes the core's ALU-result address, store data and mem_write/mem_reg strobes.
- Returns load data in the same cycle on the core's data_to_wr path.
- Holds a word-addressed data RAM plus memory-mapped LED, switch, cycle-counter and down-timer registers.

Parameters:
- RAM_DEPTH, 256, number of 32-bit RAM words (power of two, at most 1024).
- IO_BASE, 32'h0000_1000, byte address of the first I/O register.
- SYNC_STAGES, 2, flip-flop stages on sw_in.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from core ALU result. addr[1:0] ignored.
- wr_data  in  32  store data from core.
- mem_write  in  1  store strobe, sampled at clk edge.
- mem_reg  in  1  load select. rd_data is valid while high.
- rd_data  out  32  combinational load data to core.
- sw_in  in  8  asynchronous board switches.
- led_out  out  8  registered LED register.
- timer_irq  out  1  registered timer-expired flag.
- bad_addr  out  1  sticky flag: an access hit an unmapped address.

Behaviour:
Reset and read path:
- Reset (rst=0, async) clears led_out, timer_irq, bad_addr, cycle counter, timer count, reload, enable, auto-reload and sync flops.
- RAM contents are not reset.
- rd_data is purely combinational from addr and the current state. Zero-cycle load latency matches the single-cycle core.
- rd_data = 0 when mem_reg=0 or addr is unmapped.

Memory map (word = addr[31:2]):
- RAM, 0 .. 4*RAM_DEPTH-4: read async; write on edge when mem_write.
- IO_BASE+0x0 LED: R/W, bits[7:0]; upper read 0.
- IO_BASE+0x4 SW: read-only, synchronized sw_in zero-extended.
- IO_BASE+0x8 CYCLES: free-running 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF->0. Any write clears it to 0 (write wins over increment).
- IO_BASE+0xC TCOUNT: write loads both reload and count with wr_data. Read returns current count.
- IO_BASE+0x10 TCTRL: bit0 en, bit1 auto, bit2 expired (=timer_irq).
  - Write sets en/auto from wr_data[1:0].
  - Writing 1 to bit2 clears expired.

Stores to read-only registers are ignored and not flagged. Any mem_write or mem_reg cycle to an unmapped address sets bad_addr next edge. bad_addr holds until reset.

Timer state machine:
- IDLE (en=0): count holds.
- RUN (en=1, count>1): count <= count-1 each cycle.
- EXPIRE (en=1, count<=1): next edge sets expired.
  - If auto=1 and reload!=0: count <= reload, stay RUN.
  - Otherwise: count <= 0, en <= 0, go IDLE.
- Enabling with count=0 expires on the next edge. Enabling with count=1 also expires on the next edge.

Simultaneous events:
- CPU write to TCOUNT/TCTRL in the same cycle as a decrement or expire: CPU write wins for count/en/auto.
- Expire-set and write-1-to-clear of expired in the same cycle: set wins.
- Reset mid-countdown returns to IDLE with count 0 immediately.

Arithmetic and read-back:
- All counters are unsigned with wrap.
- Address compare is a full 32-bit match; addr[1:0] is don't-care.
- A read of TCTRL returns {29'b0, expired, auto, en}.

Test Plan:
- RAM: store 0xDEADBEEF to 0x10, then 0x12345678 to 0x3FC; load both with mem_reg=1 -> same-cycle rd_data equals the stored values. mem_reg=0 -> rd_data=0.
- LED/SW: store 0x1A5 to IO_BASE -> led_out=0xA5 next edge. Drive sw_in=0x3C -> SW read returns 0x3C after exactly SYNC_STAGES edges, old value before.
- CYCLES: release reset, read after 10 edges -> 10. Write any value -> next read one cycle later = 1.
- One-shot timer: TCOUNT=5, TCTRL=1 -> count reads 4,3,2,1. timer_irq=1 on the 5th edge after enable, en reads 0, count 0. Write TCTRL=4 -> irq clears.
- Auto-reload: TCOUNT=3, TCTRL=3 -> irq set every 3 cycles and count cycles 3,2,1. A clear write in the expire cycle leaves irq=1.
- Errors and reset: load from 0x2000 -> rd_data=0, bad_addr=1 next edge and sticky. Assert rst mid-countdown -> all outputs 0 asynchronously, timer IDLE.
